// File: rtl/if_fetch_ctrl_if.sv
// Bus bundle between the instruction-fetch controller and its environment
// (hazard unit, EX-stage redirect, program loader, instruction memory).
//
// Loader handshake: ld_req is held high by the loader for each cycle it
// presents a write (ld_addr/ld_data valid). Once the controller is in LOAD,
// every such cycle is consumed, and ld_ack pulses on the following edge
// (with ld_err if the address was out of range). Dropping ld_req releases
// the memory port back to fetch.
interface if_fetch_ctrl_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ack;
  logic        ld_err;
  logic [31:0] im_addr;
  logic        im_we;
  logic [31:0] im_wdata;
  logic [31:0] im_rdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [1:0]  dbg_state;

  // Controller side
  modport master (
    input  stall, br_taken, br_target, ld_req, ld_addr, ld_data, im_rdata,
    output ld_ack, ld_err, im_addr, im_we, im_wdata, pc,
           ifid_instr, ifid_pc, ifid_valid, halted, dbg_state
  );

  // Environment side
  modport slave (
    output stall, br_taken, br_target, ld_req, ld_addr, ld_data, im_rdata,
    input  ld_ack, ld_err, im_addr, im_we, im_wdata, pc,
           ifid_instr, ifid_pc, ifid_valid, halted, dbg_state
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the pc, fills the IF/ID latch from a
// combinational-read instruction memory, honours stall/redirect, and lends
// the memory port to a program loader while the CPU is parked.
module if_fetch_ctrl #(
  parameter int          IM_DEPTH     = 200,
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter int          HALT_ON_ZERO = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  if_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [31:0] LIMIT = 32'(4 * IM_DEPTH);

  state_t      state, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] ifpc_q, ifpc_n;
  logic        valid_q, valid_n;
  logic        ack_q, ack_n;
  logic        err_q, err_n;
  logic        ld_in_range;
  logic        word_is_zero;
  logic        unused_br_bits;

  assign ld_in_range    = (bus.ld_addr < LIMIT);
  assign word_is_zero   = (HALT_ON_ZERO != 0) && (bus.im_rdata == 32'd0);
  // Redirects are word-aligned, so the low target bits carry no information.
  assign unused_br_bits = ^bus.br_target[1:0];

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      ifpc_q  <= 32'd0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      ifpc_q  <= ifpc_n;
      valid_q <= valid_n;
      ack_q   <= ack_n;
      err_q   <= err_n;
    end
  end

  // Next-state: load beats redirect beats stall beats normal advance
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    instr_n = instr_q;
    ifpc_n  = ifpc_q;
    valid_n = valid_q;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      RUN: begin
        if (bus.ld_req) begin
          state_n = LOAD;
          valid_n = 1'b0;
        end else if (bus.br_taken) begin
          pc_n    = {bus.br_target[31:2], 2'b00};
          valid_n = 1'b0;
        end else if (bus.stall) begin
          // hold everything
        end else if (pc_q >= LIMIT || word_is_zero) begin
          // Out-of-range or terminating word is never latched.
          state_n = HALT;
          valid_n = 1'b0;
        end else begin
          instr_n = bus.im_rdata;
          ifpc_n  = pc_q;
          valid_n = 1'b1;
          pc_n    = pc_q + 32'd4;
        end
      end
      HALT: begin
        valid_n = 1'b0;
        if (bus.ld_req) state_n = LOAD;
      end
      LOAD: begin
        valid_n = 1'b0;
        if (bus.ld_req) begin
          ack_n = 1'b1;
          err_n = !ld_in_range;
        end else begin
          state_n = RUN;
          pc_n    = RESET_PC;
        end
      end
      default: begin
        state_n = RUN;
        valid_n = 1'b0;
      end
    endcase
  end

  // Memory port mux: loader owns the port only in LOAD
  always_comb begin
    bus.im_addr  = pc_q;
    bus.im_we    = 1'b0;
    bus.im_wdata = bus.ld_data;
    if (state == LOAD) begin
      bus.im_addr = {bus.ld_addr[31:2], 2'b00};
      bus.im_we   = bus.ld_req && ld_in_range;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc    = ifpc_q;
  assign bus.ifid_valid = valid_q;
  assign bus.ld_ack     = ack_q;
  assign bus.ld_err     = err_q;
  assign bus.halted     = (state == HALT);
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a default instance plus a small IM_DEPTH=4,
// HALT_ON_ZERO=0 instance, each with a behavioural instruction memory.
module tb_if_fetch_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_fetch_ctrl_if bus ();
  if_fetch_ctrl_if bus4 ();

  if_fetch_ctrl #(.IM_DEPTH(200), .RESET_PC(32'd0), .HALT_ON_ZERO(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
  if_fetch_ctrl #(.IM_DEPTH(4), .RESET_PC(32'd0), .HALT_ON_ZERO(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.master)
  );

  // ---------------- instruction memories ----------------
  logic [31:0] mem  [0:255];
  logic [31:0] mem4 [0:3];

  assign bus.im_rdata  = (bus.im_addr[31:2] < 30'd200) ? mem[bus.im_addr[9:2]] : 32'hBAD0_BAD0;
  assign bus4.im_rdata = (bus4.im_addr[31:2] < 30'd4) ? mem4[bus4.im_addr[3:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (bus.im_we && bus.im_addr[31:2] < 30'd200) mem[bus.im_addr[9:2]] = bus.im_wdata;
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] exp4_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic chk4_en = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  logic        prev_v = 1'b0, prev_v4 = 1'b0;
  logic [31:0] prev_pc = '0, prev_pc4 = '0;

  // Pop one expected {ifid_pc, ifid_instr} per newly latched instruction
  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.ifid_valid && (!prev_v || bus.ifid_pc != prev_pc)) begin
      if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        check("ifid", {bus.ifid_pc, bus.ifid_instr}, e);
      end
    end
    prev_v  = bus.ifid_valid;
    prev_pc = bus.ifid_pc;
    if (chk4_en && bus4.ifid_valid && (!prev_v4 || bus4.ifid_pc != prev_pc4)) begin
      if (exp4_q.size() == 0) check("sb4_underflow", 64'(exp4_q.size()), 64'd1);
      else begin
        e = exp4_q.pop_front();
        check("ifid4", {bus4.ifid_pc, bus4.ifid_instr}, e);
      end
    end
    prev_v4  = bus4.ifid_valid;
    prev_pc4 = bus4.ifid_pc;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 200 && !bus.halted; i++) tick();
    check(tag, 64'(bus.halted), 64'd1);
  endtask

  task automatic push_seq(input int first_word, input int last_word);
    for (int i = first_word; i <= last_word; i++) exp_q.push_back({32'(i * 4), mem[i]});
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] saved_w2;

  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus4.stall = 1'b0; bus4.br_taken = 1'b0; bus4.br_target = '0;
    bus4.ld_req = 1'b0; bus4.ld_addr = '0; bus4.ld_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = (i < 18) ? (32'h8000_0000 | $urandom_range(1, 32'h7FFF_FFFF)) : 32'd0;
    for (int i = 0; i < 4; i++) begin
      mem4[i] = 32'h4000_0000 | $urandom_range(1, 32'hFFFF);
      exp4_q.push_back({32'(i * 4), mem4[i]});
    end
    push_seq(0, 17);

    // Reset values
    tick();
    check("rst_pc", 64'(bus.pc), 64'd0);
    check("rst_valid", 64'(bus.ifid_valid), 64'd0);
    check("rst_instr", 64'(bus.ifid_instr), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_ack", 64'({bus.ld_ack, bus.ld_err, bus.im_we}), 64'd0);

    // Free run to a zero word
    rst_n = 1'b1;
    wait_halt("halt_zero");
    check("halt_pc", 64'(bus.pc), 64'd72);
    check("halt_ifid_pc", 64'(bus.ifid_pc), 64'd68);
    tick();
    check("halt_hold", 64'({bus.ifid_valid, bus.pc}), 64'd72);
    check("sb_drain1", 64'(exp_q.size()), 64'd0);

    // Small memory without zero-halt: stops at pc=16
    check("d4_halted", 64'(bus4.halted), 64'd1);
    check("d4_pc", 64'(bus4.pc), 64'd16);
    check("d4_ifid_pc", 64'(bus4.ifid_pc), 64'd12);
    check("d4_drain", 64'(exp4_q.size()), 64'd0);
    chk4_en = 1'b0;

    // Stall then redirect under stall
    rst_n = 1'b0;
    tick();
    push_seq(0, 4);
    push_seq(10, 17);
    rst_n = 1'b1;
    tick(); tick();
    check("pre_stall_pc", 64'(bus.pc), 64'd8);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", {bus.pc, bus.ifid_pc}, {32'd8, 32'd4});
    end
    bus.stall = 1'b0;
    tick();
    check("stall_resume", {bus.pc, bus.ifid_pc}, {32'd12, 32'd8});
    tick(); tick();
    check("pre_br_pc", 64'(bus.pc), 64'd20);
    bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h2B;
    tick();
    check("br_pc", {bus.pc, 31'd0, bus.ifid_valid}, {32'h28, 32'd0});
    bus.stall = 1'b0; bus.br_taken = 1'b0;
    tick();
    check("br_first", {bus.ifid_pc, 31'd0, bus.ifid_valid}, {32'h28, 32'd1});
    wait_halt("halt_after_br");
    check("sb_drain2", 64'(exp_q.size()), 64'd0);

    // Loader from HALT: one good write, one out-of-range write
    bus.ld_req = 1'b1; bus.ld_addr = 32'd0; bus.ld_data = 32'h0129_4015;
    tick();
    check("ld_we", {bus.im_addr, 30'd0, bus.im_we, bus.ld_ack}, {32'd0, 32'd2});
    tick();
    check("ld_ack1", 64'({bus.ld_ack, bus.ld_err}), 64'b10);
    check("ld_mem0", 64'(mem[0]), 64'h0129_4015);
    bus.ld_addr = 32'd800; bus.ld_data = 32'hDEAD;
    #1;
    check("ld_oor_we", 64'(bus.im_we), 64'd0);
    tick();
    check("ld_ack2", 64'({bus.ld_ack, bus.ld_err}), 64'b11);
    bus.ld_req = 1'b0;
    exp_q.push_back({32'd0, 32'h0129_4015});
    tick();
    check("ld_exit", {bus.pc, 28'd0, bus.ld_ack, bus.ld_err, bus.halted, bus.ifid_valid}, 64'd0);
    tick();
    check("ld_first_fetch", {bus.pc, bus.ifid_instr}, {32'd4, 32'h0129_4015});

    // Reset in the middle of a loader sequence
    saved_w2 = mem[2];
    bus.ld_req = 1'b1; bus.ld_addr = 32'd4; bus.ld_data = 32'h1111;
    tick(); tick();
    check("ld6_ack", 64'(bus.ld_ack), 64'd1);
    bus.ld_addr = 32'd8; bus.ld_data = 32'h2222;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {bus.pc, 27'd0, bus.ld_ack, bus.ld_err, bus.im_we, bus.halted, bus.ifid_valid}, 64'd0);
    check("async_rst_instr", 64'(bus.ifid_instr), 64'd0);
    bus.ld_req = 1'b0;
    tick();
    check("rst_no_ack", 64'(bus.ld_ack), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_no_ack2", 64'(bus.ld_ack), 64'd0);
    check("rst_no_write", 64'(mem[2]), 64'(saved_w2));
    check("sb_drain3", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
